muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit for the EX stage. It is the successor to the MUL-only
//  multiplier. It covers all eight M-extension ops, and its width and radix are parametrised.
//  Operation is start/busy/done: an op issues from EX, a tagged one-cycle done pulse returns
//  the result, and a kill input lets the hazard unit abort a flushed op.
//  Divide special cases exit early.
// PARAMETERS
//  XLEN            32  operand/result width
//  BITS_PER_CYCLE  1   quotient/product bits retired per iteration; legal values 1, 2, 4; must divide XLEN
//  TAG_W           5   destination-register tag width
// PORTS
//  clk     in   1       clock, rising edge
//  reset   in   1       asynchronous, active-high reset
//  start   in   1       issue request; sampled only when busy=0
//  funct3  in   3       000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  a       in   XLEN    rs1 operand (dividend / multiplicand)
//  b       in   XLEN    rs2 operand (divisor / multiplier)
//  rd_in   in   TAG_W   destination tag captured with the op
//  kill    in   1       synchronous abort of the op in flight
//  busy    out  1       op in flight; the pipeline must hold EX/MEM while high
//  done    out  1       one-cycle pulse; result/rd_out valid
//  result  out  XLEN    op result; holds until the next done
//  rd_out  out  TAG_W   tag of the op that produced result
// BEHAVIOUR
//  - Reset (async): state=IDLE, busy=0, done=0, result=0, rd_out=0; effect is immediate, including mid-op.
//  - FSM IDLE -> RUN -> FINISH -> IDLE. N = XLEN/BITS_PER_CYCLE. busy = (state != IDLE).
//  - Start accepted at edge E0 (IDLE, start=1, kill=0): latch funct3, rd_in, operand magnitudes, result signs; go to RUN.
//  - RUN: shift-add (mul) or restoring shift-subtract (div), BITS_PER_CYCLE bits per edge.
//  - RUN: the iteration counter wraps to 0 after N edges, and the FSM then enters FINISH.
//  - FINISH: apply sign fix and select the low or high word, quotient or remainder.
//    At the next edge, register result and rd_out, set done=1, return to IDLE.
//  - Normal latency: busy high N+1 cycles; done high in the cycle after edge E0+N+1 (N=32: edge E0+33).
//  - Signedness: MULH and DIV/REM are signed x signed; MULHSU is signed a x unsigned b; MULHU, DIVU, REMU are unsigned.
//  - Signedness: the remainder takes the sign of the dividend. Products are 2*XLEN internally.
//  - Early exit: IDLE goes straight to FINISH (busy 1 cycle, done after edge E0+1) when either holds:
//      b=0: DIV/DIVU give all-ones; REM/REMU give a.
//      Signed overflow (a=-2^(XLEN-1), b=-1): DIV gives a; REM gives 0.
//  - start while busy=1: ignored, no queueing.
//  - start in the cycle done=1: accepted, since the FSM is IDLE, giving back-to-back ops.
//  - kill=1: state goes to IDLE at the next edge, no done for the killed op, busy=0 the cycle after.
//    result and rd_out are unchanged. kill beats start in the same cycle. kill in IDLE has no effect.
//  - done never asserts without a prior accepted, unkilled start.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//    - MUL/MULH/MULHSU/MULHU use a single-cycle combinational 2*XLEN product.
//    - These ops go IDLE -> FINISH with busy high 1 cycle and done after edge E0+1.
//    - Divide ops are unchanged.
//  MULDIV_FAST_MUL_EN undefined: all multiplies iterate with normal latency; no wide multiplier is inferred.
// TESTING (XLEN=32, BITS_PER_CYCLE=1 unless stated)
//  1. MUL a=7, b=0xFFFFFFFD, rd_in=5 -> result 0xFFFFFFEB, rd_out=5.
//     busy high exactly 33 cycles; done is a single pulse after edge E0+33.
//  2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//     MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//     Repeat the ops with BITS_PER_CYCLE=4: same results, busy 9 cycles.
//  4. DIVU 9/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
//     REM 0x80000000/0xFFFFFFFF -> 0; each with busy 1 cycle.
//  5. kill in the 10th RUN cycle: no done, busy=0 next cycle, result unchanged.
//     start together with kill: ignored. New DIVU 100/7 next cycle -> 14.
//     reset mid-RUN: all outputs 0 immediately.
//  6. Back-to-back MUL then DIV, the second start raised in the done cycle: two done pulses, tags 3 then 4.
//     A start pulse while busy produces no extra done.
//     With MULDIV_FAST_MUL_EN: MUL 7*3 -> 21, busy 1 cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake, tagged result and kill.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational product.
module muldiv_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned TAG_W          = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] rd_in,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out
);

  localparam int unsigned N    = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             neg_q, neg_d;
  // hi: product high word / remainder; lo: multiplier then product low word / dividend then quotient
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [TAG_W-1:0] rd_out_q, rd_out_d;

  // Issue decode
  logic            is_div, a_signed, b_signed, sa, sb, div_zero, div_ovf, neg_issue;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    is_div    = funct3[2];
    a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
                (funct3 == 3'b110);
    b_signed  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa        = a_signed & a[XLEN-1];
    sb        = b_signed & b[XLEN-1];
    mag_a     = sa ? -a : a;
    mag_b     = sb ? -b : b;
    div_zero  = is_div && (b == '0);
    div_ovf   = is_div && !funct3[0] && (a == MinNeg) && (b == '1);
    // Remainder follows the dividend; quotient and products follow the XOR of signs
    neg_issue = (is_div && funct3[1]) ? sa : (sa ^ sb);
  end

  // One iteration: BITS_PER_CYCLE radix-2 steps of shift-add or restoring shift-subtract
  logic [XLEN-1:0] it_hi, it_lo;
  logic [XLEN:0]   trial, sum;

  always_comb begin
    it_hi = hi_q;
    it_lo = lo_q;
    trial = '0;
    sum   = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (op_q[2]) begin
        trial = {it_hi, it_lo[XLEN-1]} - {1'b0, opb_q};
        if (!trial[XLEN]) begin
          it_hi = trial[XLEN-1:0];
          it_lo = {it_lo[XLEN-2:0], 1'b1};
        end else begin
          it_hi = {it_hi[XLEN-2:0], it_lo[XLEN-1]};
          it_lo = {it_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        sum   = {1'b0, it_hi} + (it_lo[0] ? {1'b0, opb_q} : '0);
        it_lo = {sum[0], it_lo[XLEN-1:1]};
        it_hi = sum[XLEN:1];
      end
    end
  end

  // Sign fix and word select
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix, fin_res;

  always_comb begin
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    div_sel  = op_q[1] ? hi_q : lo_q;
    div_fix  = neg_q ? -div_sel : div_sel;
    if (op_q[2]) begin
      fin_res = div_fix;
    end else if (op_q[1:0] == 2'b00) begin
      fin_res = prod_fix[XLEN-1:0];
    end else begin
      fin_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    tag_d    = tag_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    done_d   = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;
    unique case (state_q)
      StIdle: begin
        if (start && !kill) begin
          op_d  = funct3;
          tag_d = rd_in;
          cnt_d = '0;
          if (div_zero) begin
            neg_d   = 1'b0;
            lo_d    = '1;
            hi_d    = a;
            state_d = StFinish;
          end else if (div_ovf) begin
            neg_d   = 1'b0;
            lo_d    = a;
            hi_d    = '0;
            state_d = StFinish;
          end else begin
            neg_d   = neg_issue;
            hi_d    = '0;
            lo_d    = is_div ? mag_a : mag_b;
            opb_d   = is_div ? mag_b : mag_a;
            state_d = StRun;
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div) begin
              {hi_d, lo_d} = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
              state_d      = StFinish;
            end
`endif
          end
        end
      end
      StRun: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
          hi_d  = it_hi;
          lo_d  = it_lo;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = StFinish;
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
        if (!kill) begin
          result_d = fin_res;
          rd_out_d = tag_q;
          done_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: radix-2 instance for all ops, radix-16 instance for divides.
module tb_muldiv_unit;

  localparam logic [2:0] OpMul = 3'b000, OpMulh = 3'b001, OpMulhsu = 3'b010, OpMulhu = 3'b011;
  localparam logic [2:0] OpDiv = 3'b100, OpDivu = 3'b101, OpRem = 3'b110, OpRemu = 3'b111;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulBusy = 1;
`else
  localparam int MulBusy = 33;
`endif

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, kill, start4;
  logic [2:0]  funct3, funct3_4;
  logic [31:0] a, b, a4, b4;
  logic [4:0]  rd_in, rd_in4;
  logic        busy, done, busy4, done4;
  logic [31:0] result, result4;
  logic [4:0]  rd_out, rd_out4;

  exp_t        sb_q[$];
  exp_t        sb4_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_tag = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) u_dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b), .rd_in(rd_in),
    .kill(kill), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(5)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .funct3(funct3_4), .a(a4), .b(b4),
    .rd_in(rd_in4), .kill(1'b0), .busy(busy4), .done(done4), .result(result4),
    .rd_out(rd_out4)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, required 0x%h", nm, act, exp);
    end
  endfunction

  // Monitors: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: result=0x%h rd_out=%0d, required no done", result, rd_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, " result"}, result, e.res);
        chk({e.name, " rd_out"}, 32'(rd_out), 32'(e.tag));
      end
    end
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (sb4_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done4: result=0x%h, required no done", result4);
      end else begin
        exp_t e;
        e = sb4_q.pop_front();
        chk({e.name, " r4 result"}, result4, e.res);
        chk({e.name, " r4 rd_out"}, 32'(rd_out4), 32'(e.tag));
      end
    end
  end

  // Issue one op; returns at the negedge where busy has dropped (the done cycle)
  task automatic run_op(input logic [2:0] f, input logic [31:0] ai, input logic [31:0] bi,
                        input logic [4:0] tag, input logic [31:0] exp, input int exp_busy,
                        input string nm, input bit now);
    int cnt;
    exp_t e;
    if (!now) @(negedge clk);
    funct3 = f; a = ai; b = bi; rd_in = tag; start = 1'b1;
    e.res = exp; e.tag = tag; e.name = nm;
    sb_q.push_back(e);
    last_res = exp;
    last_tag = tag;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, 32'(cnt), 32'(exp_busy));
  endtask

  task automatic run_op4(input logic [2:0] f, input logic [31:0] ai, input logic [31:0] bi,
                         input logic [4:0] tag, input logic [31:0] exp, input string nm);
    int cnt;
    exp_t e;
    @(negedge clk);
    funct3_4 = f; a4 = ai; b4 = bi; rd_in4 = tag; start4 = 1'b1;
    e.res = exp; e.tag = tag; e.name = nm;
    sb4_q.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    cnt = 0;
    while (busy4 === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk({nm, " r4 busy_cycles"}, 32'(cnt), 32'd9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; a = '0; b = '0; rd_in = '0;
    start4 = 1'b0; funct3_4 = '0; a4 = '0; b4 = '0; rd_in4 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", 32'(rd_out), 32'd0);
    reset = 1'b0;

    run_op(OpMul, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MulBusy, "mul_7_m3", 1'b0);
    run_op(OpMulh, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, MulBusy, "mulh_min", 1'b0);
    run_op(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, MulBusy, "mulhu", 1'b0);
    run_op(OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, MulBusy, "mulhsu",
           1'b0);

    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33, "div_m7_2", 1'b0);
    run_op(OpRem, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33, "rem_m7_2", 1'b0);
    run_op(OpDivu, 32'd100, 32'd7, 5'd9, 32'd14, 33, "divu_100_7", 1'b0);
    run_op(OpRemu, 32'd100, 32'd7, 5'd10, 32'd2, 33, "remu_100_7", 1'b0);

    run_op4(OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, "div_m7_2");
    run_op4(OpRem, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, "rem_m7_2");
    run_op4(OpDivu, 32'd100, 32'd7, 5'd9, 32'd14, "divu_100_7");
    run_op4(OpRemu, 32'd100, 32'd7, 5'd10, 32'd2, "remu_100_7");

    run_op(OpDivu, 32'd9, 32'd0, 5'd11, 32'hFFFF_FFFF, 1, "divu_by0", 1'b0);
    run_op(OpRem, 32'd5, 32'd0, 5'd12, 32'd5, 1, "rem_by0", 1'b0);
    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1, "div_ovf", 1'b0);
    run_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 1, "rem_ovf", 1'b0);

    // Kill in the 10th RUN cycle
    @(negedge clk);
    funct3 = OpDivu; a = 32'd1000; b = 32'd3; rd_in = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("kill busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill busy_after", 32'(busy), 32'd0);
    chk("kill done", 32'(done), 32'd0);
    chk("kill result_held", result, last_res);
    chk("kill rd_out_held", 32'(rd_out), 32'(last_tag));

    // start with kill in IDLE is ignored
    funct3 = OpDivu; a = 32'd50; b = 32'd5; rd_in = 5'd21; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("start_with_kill busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    run_op(OpDivu, 32'd100, 32'd7, 5'd22, 32'd14, 33, "divu_after_kill", 1'b1);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    funct3 = OpMulhu; a = 32'h1234_5678; b = 32'h9ABC_DEF0; rd_in = 5'd23; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset result", result, 32'd0);
    chk("midreset rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_res = '0;
    last_tag = '0;

    // Back-to-back: second start in the done cycle, plus a stray start while busy
    run_op(OpMul, 32'd6, 32'd7, 5'd3, 32'd42, MulBusy, "b2b_mul", 1'b0);
    fork
      run_op(OpDiv, 32'd100, 32'hFFFF_FFFB, 5'd4, 32'hFFFF_FFEC, 33, "b2b_div", 1'b1);
      begin
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join

    run_op(OpMul, 32'd7, 32'd3, 5'd15, 32'd21, MulBusy, "mul_7_3", 1'b0);

    repeat (40) @(negedge clk);
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    chk("scoreboard4 drained", 32'(sb4_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
